// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation at the tail, out-of-order completion
// by index, and in-order retirement of up to two entries per cycle from the
// head. Retired entries hand back the physical tag their destination replaced.
module reorder_buffer #(
   parameter int ROB_SIZE = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enqueue_enable,
   input  logic [5:0] enqueue_old_tag,
   input  logic       wakeup_active,
   input  logic [5:0] wakeup_rob_index,
   output logic [5:0] next_rob_index,
   output logic       rob_full,
   output logic [5:0] freed_tag_1,
   output logic [5:0] freed_tag_2
);

   localparam int AW = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(ROB_SIZE - 1);
   localparam logic [AW-1:0] ONE_IDX  = AW'(1);
   localparam logic [6:0]    SIZE_CNT = 7'(ROB_SIZE);

   // Per-entry state
   logic          valid_q [ROB_SIZE];
   logic          done_q  [ROB_SIZE];
   logic [5:0]    tag_q   [ROB_SIZE];

   // Pointers and occupancy
   logic [AW-1:0] head_q, tail_q;
   logic [6:0]    count_q;

   // Next-cycle decisions
   logic [AW-1:0] head_plus1;
   logic [AW-1:0] head_d, tail_d;
   logic [6:0]    count_d;
   logic [AW-1:0] wake_idx;
   logic          wake_ok;
   logic          enq;
   logic          ret0, ret1;
   logic [5:0]    freed1_d, freed2_d;

   // Pointers advance by one and wrap at ROB_SIZE, which need not be a power of two.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + ONE_IDX;
   endfunction

   assign rob_full       = (count_q == SIZE_CNT);
   assign next_rob_index = 6'(tail_q);

   // Decide enqueue, wakeup and which head entries retire this cycle.
   always_comb begin
      wake_idx   = wakeup_rob_index[AW-1:0];
      head_plus1 = ptr_inc(head_q);
      enq        = enqueue_enable && !rob_full;
      // Out-of-range indices are rejected before truncation can alias them.
      // Only valid entries accept a wakeup, so the slot being enqueued this
      // cycle (always invalid when enqueue succeeds) ignores it.
      wake_ok    = wakeup_active
                   && ({26'd0, wakeup_rob_index} < 32'(ROB_SIZE))
                   && valid_q[wake_idx];
      ret0       = valid_q[head_q]
                   && (done_q[head_q] || (wake_ok && (wake_idx == head_q)));
      ret1       = ret0 && valid_q[head_plus1]
                   && (done_q[head_plus1] || (wake_ok && (wake_idx == head_plus1)));
      tail_d     = enq ? ptr_inc(tail_q) : tail_q;
      head_d     = ret1 ? ptr_inc(head_plus1) : (ret0 ? head_plus1 : head_q);
      count_d    = count_q + {6'd0, enq} - {6'd0, ret0} - {6'd0, ret1};
      freed1_d   = ret0 ? tag_q[head_q]     : 6'd0;
      freed2_d   = ret1 ? tag_q[head_plus1] : 6'd0;
   end

   // Pointer, occupancy and freed-tag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         freed_tag_1 <= '0;
         freed_tag_2 <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         freed_tag_1 <= freed1_d;
         freed_tag_2 <= freed2_d;
      end
   end

   // Entry array update: retirement clears last so it wins over a same-cycle wakeup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            valid_q[i] <= 1'b0;
            done_q[i]  <= 1'b0;
            tag_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            if (wake_ok && (wake_idx == AW'(i))) begin
               done_q[i] <= 1'b1;
            end
            if (enq && (tail_q == AW'(i))) begin
               valid_q[i] <= 1'b1;
               done_q[i]  <= 1'b0;
               tag_q[i]   <= enqueue_old_tag;
            end
            if ((ret0 && (head_q == AW'(i))) || (ret1 && (head_plus1 == AW'(i)))) begin
               valid_q[i] <= 1'b0;
               done_q[i]  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with ROB_SIZE=4 and hand-computed results.
module tb_reorder_buffer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enqueue_enable = 1'b0;
   logic [5:0] enqueue_old_tag = '0;
   logic       wakeup_active = 1'b0;
   logic [5:0] wakeup_rob_index = '0;
   logic [5:0] next_rob_index;
   logic       rob_full;
   logic [5:0] freed_tag_1;
   logic [5:0] freed_tag_2;

   int checks = 0;
   int errors = 0;

   reorder_buffer #(.ROB_SIZE(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .enqueue_enable   (enqueue_enable),
      .enqueue_old_tag  (enqueue_old_tag),
      .wakeup_active    (wakeup_active),
      .wakeup_rob_index (wakeup_rob_index),
      .next_rob_index   (next_rob_index),
      .rob_full         (rob_full),
      .freed_tag_1      (freed_tag_1),
      .freed_tag_2      (freed_tag_2)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Set the inputs for the coming edge, take the edge, then sample just after it.
   task automatic step(input logic enq, input logic [5:0] tag,
                       input logic wake, input logic [5:0] widx);
      enqueue_enable   = enq;
      enqueue_old_tag  = tag;
      wakeup_active    = wake;
      wakeup_rob_index = widx;
      @(posedge clk);
      #1;
      enqueue_enable   = 1'b0;
      enqueue_old_tag  = '0;
      wakeup_active    = 1'b0;
      wakeup_rob_index = '0;
   endtask

   task automatic check_freed(input string tag, input logic [5:0] e1, input logic [5:0] e2);
      check({tag, ".freed1"}, freed_tag_1, e1);
      check({tag, ".freed2"}, freed_tag_2, e2);
   endtask

   initial begin
      // Reset state, observed while reset is still held
      #12;
      check("rst.next", next_rob_index, 6'd0);
      check("rst.full", {5'd0, rob_full}, 6'd0);
      check_freed("rst", 6'd0, 6'd0);
      rst_n = 1'b1;

      // Idle edge after reset
      step(1'b0, 6'd0, 1'b0, 6'd0);
      check_freed("idle0", 6'd0, 6'd0);
      check("idle0.next", next_rob_index, 6'd0);

      // Fill with old tags 1..4
      for (int i = 0; i < 4; i++) begin
         check("fill.idx", next_rob_index, 6'(i));
         step(1'b1, 6'(i + 1), 1'b0, 6'd0);
         check_freed("fill", 6'd0, 6'd0);
      end
      check("fill.full", {5'd0, rob_full}, 6'd1);
      check("fill.next", next_rob_index, 6'd0);

      // Enqueue while full is dropped
      step(1'b1, 6'd9, 1'b0, 6'd0);
      check("ovf.next", next_rob_index, 6'd0);
      check("ovf.full", {5'd0, rob_full}, 6'd1);
      check_freed("ovf", 6'd0, 6'd0);

      // Out-of-order completion, then head wake releases two (bypass on head)
      step(1'b0, 6'd0, 1'b1, 6'd1);
      check_freed("wake1", 6'd0, 6'd0);
      step(1'b0, 6'd0, 1'b1, 6'd2);
      check_freed("wake2", 6'd0, 6'd0);
      step(1'b0, 6'd0, 1'b1, 6'd0);
      check_freed("wake0", 6'd1, 6'd2);
      check("wake0.full", {5'd0, rob_full}, 6'd0);

      // Remaining done entry drains, then nothing
      step(1'b0, 6'd0, 1'b0, 6'd0);
      check_freed("drain", 6'd3, 6'd0);
      step(1'b0, 6'd0, 1'b0, 6'd0);
      check_freed("drain2", 6'd0, 6'd0);

      // Last entry
      step(1'b0, 6'd0, 1'b1, 6'd3);
      check_freed("wake3", 6'd4, 6'd0);
      step(1'b0, 6'd0, 1'b0, 6'd0);
      check_freed("empty", 6'd0, 6'd0);
      check("empty.full", {5'd0, rob_full}, 6'd0);
      check("empty.next", next_rob_index, 6'd0);

      // Wrapped enqueue at index 0 with a same-cycle wakeup to it (ignored)
      step(1'b1, 6'd5, 1'b1, 6'd0);
      check_freed("wrap.enq", 6'd0, 6'd0);
      check("wrap.next", next_rob_index, 6'd1);
      step(1'b0, 6'd0, 1'b0, 6'd0);
      check_freed("wrap.hold", 6'd0, 6'd0);
      step(1'b0, 6'd0, 1'b1, 6'd0);
      check_freed("wrap.ret", 6'd5, 6'd0);

      // Two more entries at 1 and 2; out-of-range wakeup 5 must not alias to 1
      step(1'b1, 6'd6, 1'b0, 6'd0);
      step(1'b1, 6'd7, 1'b0, 6'd0);
      check("two.next", next_rob_index, 6'd3);
      step(1'b0, 6'd0, 1'b1, 6'd5);
      check_freed("oor", 6'd0, 6'd0);
      step(1'b0, 6'd0, 1'b0, 6'd0);
      check_freed("oor.hold", 6'd0, 6'd0);

      // Enqueue at 3 with a wakeup of head 1 in the same cycle
      step(1'b1, 6'd8, 1'b1, 6'd1);
      check_freed("simul", 6'd6, 6'd0);
      check("simul.next", next_rob_index, 6'd0);
      step(1'b0, 6'd0, 1'b1, 6'd2);
      check_freed("simul2", 6'd7, 6'd0);
      step(1'b0, 6'd0, 1'b1, 6'd3);
      check_freed("simul3", 6'd8, 6'd0);

      // Enqueue then reset mid-operation: entry discarded, no tag freed
      step(1'b1, 6'd10, 1'b0, 6'd0);
      check("mid.next", next_rob_index, 6'd1);
      rst_n = 1'b0;
      #1;
      check("midrst.next", next_rob_index, 6'd0);
      check("midrst.full", {5'd0, rob_full}, 6'd0);
      check_freed("midrst", 6'd0, 6'd0);
      #1;
      rst_n = 1'b1;
      step(1'b0, 6'd0, 1'b1, 6'd0);
      check_freed("postrst", 6'd0, 6'd0);
      check("postrst.next", next_rob_index, 6'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_SIZE, default 64, number of ROB entries; legal range 2..64.
REQ-002 Port clk input 1: sole clock; all state updates on rising edge.
REQ-003 Port rst_n input 1: reset, asynchronous and active-low.
REQ-004 Port enqueue_enable input 1: allocate one entry at the tail this cycle.
REQ-005 Port enqueue_old_tag input 6: previous physical tag of the renamed destination; freed at retire; 0 = no tag.
REQ-006 Port wakeup_active input 1: mark the entry at wakeup_rob_index complete this cycle.
REQ-007 Port wakeup_rob_index input 6: ROB index being completed.
REQ-008 Port next_rob_index output 6: index the next enqueued entry will receive (tail pointer).
REQ-009 Port rob_full output 1: all ROB_SIZE entries valid.
REQ-010 Port freed_tag_1 output 6: registered; old tag of oldest entry retired at last edge; 0 = none.
REQ-011 Port freed_tag_2 output 6: registered; old tag of second-oldest entry retired at last edge; 0 = none.

Function
REQ-012 Per entry SHALL hold: valid, done, old_tag[5:0]; plus head pointer, tail pointer and count in range 0..ROB_SIZE.
REQ-013 Enqueue SHALL act when enqueue_enable=1 and rob_full=0: entry[tail] valid=1, done=0, old_tag=enqueue_old_tag; tail advances by 1 modulo ROB_SIZE.
REQ-014 Enqueue SHALL be ignored when rob_full=1 at the edge; retirement in the same cycle does not make room.
REQ-015 next_rob_index SHALL equal the tail pointer, combinational from state.
REQ-016 Wakeup SHALL set done=1 on entry[wakeup_rob_index] only if that entry is valid; an invalid entry or index >= ROB_SIZE is ignored.
REQ-017 Retire SHALL occur at each edge, in order from head, up to 2 entries per cycle.
REQ-018 An entry is retirable when valid and either done=1 or the same-cycle wakeup targets it (wakeup bypass).
REQ-019 Retire SHALL take head if retirable, then head+1 (mod ROB_SIZE) only if head also retires and head+1 is retirable.
REQ-020 Retired entries SHALL be cleared (valid=0, done=0); head advances by the number retired; count updates by enqueued minus retired.
REQ-021 freed_tag_1 SHALL register old_tag of the first retired entry, else 0.
REQ-022 freed_tag_2 SHALL register old_tag of the second retired entry, else 0.
REQ-023 A freed_tag output is driven 0 on any cycle with no corresponding retirement, including enqueue-only cycles.
REQ-024 Pointers SHALL wrap modulo ROB_SIZE; empty is count=0, full is count=ROB_SIZE.
REQ-025 Simultaneous enqueue, wakeup and retire in one cycle SHALL all take effect; a wakeup targeting the entry being enqueued that cycle is ignored.

Reset
REQ-026 rst_n=0 SHALL immediately clear all valid and done bits, head=tail=count=0, freed_tag_1=freed_tag_2=0, next_rob_index=0, rob_full=0.
REQ-027 Reset asserted mid-operation SHALL discard all entries without producing freed tags.

Verification (ROB_SIZE=4)
REQ-028 Reset, then idle edge -> freed_tag_1=freed_tag_2=0, next_rob_index=0.
REQ-029 Enqueue old tags 1,2,3,4 on four edges -> four distinct indices 0..3, freed tags 0 throughout, rob_full=1.
REQ-030 Wake idx1, then idx2 -> freed tags 0 on both edges; then wake idx0 -> freed_tag_1=1, freed_tag_2=2.
REQ-031 Next idle edge -> freed_tag_1=3, freed_tag_2=0; following idle edge -> both 0.
REQ-032 Wake idx3 -> freed_tag_1=4, freed_tag_2=0; next idle edge -> both 0, ROB empty.
REQ-033 Enqueue a fifth entry while full -> ignored, tail unchanged; after wrap, enqueue at index 0 and retire -> correct old tag freed.
